// File: rtl/aoc_axil_regfile_pkg.sv
// Shared constants and register-map helpers for the aoc AXI4-Lite register file.
// The index helpers keep the map arithmetic in one place for RTL and bench alike.
package aoc_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam int LVL_LSB   = 0;
    localparam int FULL_BIT  = 16;
    localparam int EMPTY_BIT = 17;
    localparam int OVF_BIT   = 18;

    function automatic int idx_push(input int n);
        return n;
    endfunction

    function automatic int idx_status(input int n);
        return n + 1;
    endfunction

    function automatic int idx_ro_base(input int n);
        return n + 2;
    endfunction

endpackage

// File: rtl/aoc_axil_regfile_fifo.sv
// First-word-fall-through synchronous FIFO feeding puzzle-input words to the solver.
// Pushes while full and pops while empty are ignored; the caller decides what they mean.
module aoc_sync_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 16,
    localparam int PTR_W     = $clog2(DEPTH),
    localparam int LVL_W     = PTR_W + 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] head,
    output logic [LVL_W-1:0]      level,
    output logic                  full,
    output logic                  empty
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic                  do_push;
    logic                  do_pop;

    assign full    = (level == LVL_W'(DEPTH));
    assign empty   = (level == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    // Head reads as zero when empty so the stream data is clean out of reset.
    assign head    = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/aoc_axil_regfile.sv
// AXI4-Lite slave register file for the aoc solver: RW control words, RO result words,
// a STATUS word and a PUSH port that streams puzzle input to the solver through a FIFO.
module aoc_axil_regfile
    import aoc_pkg::*;
#(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 6,
    parameter int NUM_RW_REGS        = 4,
    parameter int NUM_RO_REGS        = 2,
    parameter int FIFO_DEPTH         = 16
) (
    input  logic                            s00_axi_aclk,
    input  logic                            s00_axi_aresetn,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_awaddr,
    input  logic [2:0]                      s00_axi_awprot,
    input  logic                            s00_axi_awvalid,
    output logic                            s00_axi_awready,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_wdata,
    input  logic [3:0]                      s00_axi_wstrb,
    input  logic                            s00_axi_wvalid,
    output logic                            s00_axi_wready,
    output logic [1:0]                      s00_axi_bresp,
    output logic                            s00_axi_bvalid,
    input  logic                            s00_axi_bready,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_araddr,
    input  logic [2:0]                      s00_axi_arprot,
    input  logic                            s00_axi_arvalid,
    output logic                            s00_axi_arready,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_rdata,
    output logic [1:0]                      s00_axi_rresp,
    output logic                            s00_axi_rvalid,
    input  logic                            s00_axi_rready,
    output logic [NUM_RW_REGS*32-1:0]       rw_regs_o,
    input  logic [NUM_RO_REGS*32-1:0]       ro_regs_i,
    output logic [31:0]                     m_tdata,
    output logic                            m_tvalid,
    input  logic                            m_tready
);

    localparam int IDX_W       = C_S_AXI_ADDR_WIDTH - 2;
    localparam int LVL_W       = $clog2(FIFO_DEPTH) + 1;
    localparam int IDX_PUSH    = idx_push(NUM_RW_REGS);
    localparam int IDX_STATUS  = idx_status(NUM_RW_REGS);
    localparam int IDX_RO_BASE = idx_ro_base(NUM_RW_REGS);
    localparam int NUM_WORDS   = IDX_RO_BASE + NUM_RO_REGS;

    if (C_S_AXI_DATA_WIDTH != 32) begin : g_chk_data_width
        $error("aoc_axil_regfile: C_S_AXI_DATA_WIDTH must be 32");
    end
    if (NUM_WORDS > (1 << IDX_W)) begin : g_chk_addr_width
        $error("aoc_axil_regfile: C_S_AXI_ADDR_WIDTH too small for the register map");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || FIFO_DEPTH > 32768) begin : g_chk_fifo
        $error("aoc_axil_regfile: FIFO_DEPTH must be a power of two in 2..32768");
    end

    // Every channel transfers on the rising edge where valid and ready are both high.
    // The slave never waits for valid before raising ready; the master holds valid
    // and its payload stable until that transfer edge.

    logic                   ready_en;
    logic                   aw_held;
    logic                   w_held;
    logic [IDX_W-1:0]       aw_idx_q;
    logic [31:0]            w_data_q;
    logic [3:0]             w_strb_q;
    logic                   bvalid_q;
    logic [1:0]             bresp_q;
    logic                   rvalid_q;
    logic [1:0]             rresp_q;
    logic [31:0]            rdata_q;
    logic [31:0]            rw_q [NUM_RW_REGS];
    logic                   ovf_q;

    logic                   aw_hs;
    logic                   w_hs;
    logic                   b_hs;
    logic                   ar_hs;
    logic                   r_hs;
    logic                   commit;

    int                     wr_idx;
    logic                   wr_is_rw;
    logic                   wr_is_push;
    logic                   wr_is_status;
    logic                   wr_is_ro;
    logic [1:0]             wr_resp;

    int                     rd_idx;
    logic [31:0]            rd_word;
    logic [1:0]             rd_resp;
    logic [31:0]            status_word;

    logic                   fifo_push;
    logic                   fifo_pop;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic [LVL_W-1:0]       fifo_level;
    logic [31:0]            fifo_head;

    logic                   unused_bits;
    assign unused_bits = ^{s00_axi_awprot, s00_axi_arprot, s00_axi_awaddr[1:0], s00_axi_araddr[1:0]};

    // Readies are gated by ready_en so they read low during reset and come up one cycle later.
    assign s00_axi_awready = ready_en && !aw_held && !bvalid_q;
    assign s00_axi_wready  = ready_en && !w_held && !bvalid_q;
    assign s00_axi_arready = ready_en && !rvalid_q;
    assign s00_axi_bvalid  = bvalid_q;
    assign s00_axi_bresp   = bresp_q;
    assign s00_axi_rvalid  = rvalid_q;
    assign s00_axi_rresp   = rresp_q;
    assign s00_axi_rdata   = rdata_q;

    assign aw_hs  = s00_axi_awvalid && s00_axi_awready;
    assign w_hs   = s00_axi_wvalid && s00_axi_wready;
    assign b_hs   = bvalid_q && s00_axi_bready;
    assign ar_hs  = s00_axi_arvalid && s00_axi_arready;
    assign r_hs   = rvalid_q && s00_axi_rready;
    assign commit = aw_held && w_held && !bvalid_q;

    always_comb begin
        wr_idx       = int'(aw_idx_q);
        wr_is_rw     = (wr_idx < NUM_RW_REGS);
        wr_is_push   = (wr_idx == IDX_PUSH);
        wr_is_status = (wr_idx == IDX_STATUS);
        wr_is_ro     = (wr_idx >= IDX_RO_BASE) && (wr_idx < NUM_WORDS);
        wr_resp      = RESP_OKAY;
        if (!(wr_is_rw || wr_is_push || wr_is_status || wr_is_ro)) begin
            wr_resp = RESP_SLVERR;
        end else if (wr_is_push && fifo_full) begin
            wr_resp = RESP_SLVERR;
        end
    end

    always_comb begin
        status_word                 = '0;
        status_word[LVL_LSB +: 16]  = 16'(fifo_level);
        status_word[FULL_BIT]       = fifo_full;
        status_word[EMPTY_BIT]      = fifo_empty;
        status_word[OVF_BIT]        = ovf_q;
    end

    // Reads see pre-edge state, so a STATUS read racing a push commit reports the old level.
    always_comb begin
        rd_idx  = int'(s00_axi_araddr[C_S_AXI_ADDR_WIDTH-1:2]);
        rd_word = '0;
        rd_resp = RESP_OKAY;
        for (int k = 0; k < NUM_RW_REGS; k++) begin
            if (rd_idx == k) begin
                rd_word = rw_q[k];
            end
        end
        for (int k = 0; k < NUM_RO_REGS; k++) begin
            if (rd_idx == IDX_RO_BASE + k) begin
                rd_word = ro_regs_i[32*k +: 32];
            end
        end
        if (rd_idx == IDX_STATUS) begin
            rd_word = status_word;
        end
        if (rd_idx >= NUM_WORDS) begin
            rd_resp = RESP_SLVERR;
        end
    end

    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            ready_en <= 1'b0;
            aw_held  <= 1'b0;
            w_held   <= 1'b0;
            aw_idx_q <= '0;
            w_data_q <= '0;
            w_strb_q <= '0;
            bvalid_q <= 1'b0;
            bresp_q  <= RESP_OKAY;
        end else begin
            ready_en <= 1'b1;
            if (aw_hs) begin
                aw_held  <= 1'b1;
                aw_idx_q <= s00_axi_awaddr[C_S_AXI_ADDR_WIDTH-1:2];
            end
            if (w_hs) begin
                w_held   <= 1'b1;
                w_data_q <= s00_axi_wdata;
                w_strb_q <= s00_axi_wstrb;
            end
            if (commit) begin
                bvalid_q <= 1'b1;
                bresp_q  <= wr_resp;
            end else if (b_hs) begin
                bvalid_q <= 1'b0;
                aw_held  <= 1'b0;
                w_held   <= 1'b0;
            end
        end
    end

    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            for (int k = 0; k < NUM_RW_REGS; k++) begin
                rw_q[k] <= '0;
            end
        end else if (commit && wr_is_rw) begin
            for (int k = 0; k < NUM_RW_REGS; k++) begin
                for (int b = 0; b < 4; b++) begin
                    if (wr_idx == k && w_strb_q[b]) begin
                        rw_q[k][8*b +: 8] <= w_data_q[8*b +: 8];
                    end
                end
            end
        end
    end

    always_comb begin
        rw_regs_o = '0;
        for (int k = 0; k < NUM_RW_REGS; k++) begin
            rw_regs_o[32*k +: 32] = rw_q[k];
        end
    end

    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            ovf_q <= 1'b0;
        end else if (commit && wr_is_push && fifo_full) begin
            ovf_q <= 1'b1;
        end else if (commit && wr_is_status && w_data_q[OVF_BIT]) begin
            ovf_q <= 1'b0;
        end
    end

    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            rvalid_q <= 1'b0;
            rresp_q  <= RESP_OKAY;
            rdata_q  <= '0;
        end else if (ar_hs) begin
            rvalid_q <= 1'b1;
            rresp_q  <= rd_resp;
            rdata_q  <= rd_word;
        end else if (r_hs) begin
            rvalid_q <= 1'b0;
        end
    end

    // Full is judged on the pre-edge level, so a same-cycle pop cannot rescue a push.
    assign fifo_push = commit && wr_is_push && !fifo_full;
    assign fifo_pop  = m_tvalid && m_tready;
    assign m_tvalid  = !fifo_empty;
    assign m_tdata   = fifo_head;

    aoc_sync_fifo #(
        .DATA_WIDTH (32),
        .DEPTH      (FIFO_DEPTH)
    ) u_push_fifo (
        .clk       (s00_axi_aclk),
        .rst_n     (s00_axi_aresetn),
        .push      (fifo_push),
        .push_data (w_data_q),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .level     (fifo_level),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

endmodule
